// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux. It owns the mux Sel/Enable and keeps them
// constant for the length of each grant.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        mux_en,
  output logic        busy
);

  typedef enum logic {StIdle, StGrant} state_t;

  localparam logic [7:0] HoldLast = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t      state, stateNext;
  logic [3:0]  ptr, ptrNext;
  logic [7:0]  hcnt, hcntNext;
  logic [3:0]  owner, ownerNext;
  logic [15:0] gntNext;
  logic [3:0]  selNext;
  logic        enNext;

  logic        release_;
  logic [3:0]  scanBase;
  logic [31:0] reqDbl;
  logic [15:0] reqRot;
  logic        found;
  logic [3:0]  foundIdx;
  logic [3:0]  winner;

  // On a release the scan starts just past the owner, i.e. at the pointer it is about to get.
  assign scanBase = (state == StGrant) ? owner + 4'd1 : ptr;
  assign reqDbl   = {req, req};
  assign reqRot   = reqDbl[scanBase +: 16];
  assign winner   = scanBase + foundIdx;

  assign release_ = (state == StGrant) &&
                    (done || !req[owner] || ((MAX_HOLD != 0) && (hcnt == HoldLast)));

  always_comb begin
    found    = 1'b0;
    foundIdx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!found && reqRot[i]) begin
        found    = 1'b1;
        foundIdx = 4'(i);
      end
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    hcntNext  = hcnt;
    ownerNext = owner;
    gntNext   = gnt;
    selNext   = sel;
    enNext    = mux_en;
    unique case (state)
      StIdle: begin
        if (found) begin
          stateNext = StGrant;
          ownerNext = winner;
          hcntNext  = 8'd0;
          gntNext   = 16'd1 << winner;
          selNext   = winner;
          enNext    = 1'b1;
        end
      end
      StGrant: begin
        if (release_) begin
          ptrNext  = owner + 4'd1;
          hcntNext = 8'd0;
          if (found) begin
            ownerNext = winner;
            gntNext   = 16'd1 << winner;
            selNext   = winner;
          end else begin
            stateNext = StIdle;
            gntNext   = 16'd0;
            selNext   = 4'd0;
            enNext    = 1'b0;
          end
        end else if (hcnt != 8'hFF) begin
          hcntNext = hcnt + 8'd1;
        end
      end
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      ptr    <= 4'd0;
      hcnt   <= 8'd0;
      owner  <= 4'd0;
      gnt    <= 16'd0;
      sel    <= 4'd0;
      mux_en <= 1'b0;
    end else begin
      state  <= stateNext;
      ptr    <= ptrNext;
      hcnt   <= hcntNext;
      owner  <= ownerNext;
      gnt    <= gntNext;
      sel    <= selNext;
      mux_en <= enNext;
    end
  end

  assign busy = mux_en;

endmodule
